// File: rtl/button_event_if.sv
// Button event bundle: debounced button level in, registered event pulses out.
// Latency: none (wires only).
// Backpressure: none; events are single-cycle pulses that the consumer must sample.
interface button_event_if;
    logic btn;            // debounced, clk-synchronous button level
    logic pressed;        // level, high while a press is being tracked
    logic short_press;    // pulse: released before the long threshold
    logic long_press;     // pulse: long threshold reached
    logic release_pulse;  // pulse: every end of a press ('release' is a reserved word)
    logic repeat_press;   // pulse: auto-repeat while held long

    // Producer/consumer side: drives the button, observes the events
    modport master (
        output btn,
        input  pressed, short_press, long_press, release_pulse, repeat_press
    );

    // Event generator side
    modport slave (
        input  btn,
        output pressed, short_press, long_press, release_pulse, repeat_press
    );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into short/long/release (and optional repeat) pulses.
// Latency: every output is registered, 1 cycle after the deciding btn sample.
// Backpressure: none; optional auto-repeat enabled by macro BUTTON_EVENT_REPEAT_EN.
module button_event #(
    parameter int ACTIVE_HIGH   = 1,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 250000,
    parameter int NBITS         = 21
) (
    input  logic         clk,
    input  logic         reset_n,
    button_event_if.slave bus
);

    // The hold counter must be able to reach both terminal values without wrapping.
    localparam bit CFG_OK = (LONG_CYCLES >= 2) && (REPEAT_CYCLES >= 1) &&
                            ((64'd1 << NBITS) > 64'(LONG_CYCLES)) &&
                            ((64'd1 << NBITS) > 64'(REPEAT_CYCLES));

    if (!CFG_OK) begin : g_bad_cfg
        $error("button_event: illegal LONG_CYCLES/REPEAT_CYCLES/NBITS combination");
    end

    localparam logic             ACT_LVL   = (ACTIVE_HIGH != 0);
    localparam logic [NBITS-1:0] LONG_LAST = NBITS'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESS    = 2'd2,
        LONG     = 2'd3
    } state_t;

    state_t           state;
    logic [NBITS-1:0] count;
    logic             pressed_q;
    logic             short_q;
    logic             long_q;
    logic             release_q;
    logic             active;

    assign active = (bus.btn == ACT_LVL);

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [NBITS-1:0] REPEAT_LAST = NBITS'(REPEAT_CYCLES - 1);
    logic repeat_q;
`endif

    // Press classifier FSM; all pulses default low and are raised for exactly one cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= WAIT_REL;
            count     <= '0;
            pressed_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            release_q <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            release_q <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state)
                // A button still held from reset must be let go before it can count
                WAIT_REL: begin
                    if (!active) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (active) begin
                        state     <= PRESS;
                        count     <= NBITS'(1);
                        pressed_q <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!active) begin
                        state     <= IDLE;
                        short_q   <= 1'b1;
                        release_q <= 1'b1;
                        pressed_q <= 1'b0;
                        count     <= '0;
                    end else if (count == LONG_LAST) begin
                        state  <= LONG;
                        long_q <= 1'b1;
                        count  <= '0;
                    end else begin
                        count <= count + NBITS'(1);
                    end
                end
                LONG: begin
                    if (!active) begin
                        state     <= IDLE;
                        release_q <= 1'b1;
                        pressed_q <= 1'b0;
                        count     <= '0;
                    end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                        if (count == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            count    <= '0;
                        end else begin
                            count <= count + NBITS'(1);
                        end
`else
                        count <= '0;
`endif
                    end
                end
                default: begin
                    state <= WAIT_REL;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.pressed       = pressed_q;
    assign bus.short_press   = short_q;
    assign bus.long_press    = long_q;
    assign bus.release_pulse = release_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign bus.repeat_press  = repeat_q;
`else
    assign bus.repeat_press  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: per-cycle expected outputs from a run-length model.
// Latency: expectations are pushed before each edge and popped just after it.
// Backpressure: none; directed plan scenarios followed by random press lengths.
module tb_button_event;

    localparam int LONG_N = 8;
    localparam int REP_N  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic pressed;
        logic short_press;
        logic long_press;
        logic release_pulse;
        logic repeat_press;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;

    button_event_if bif();

    button_event #(
        .ACTIVE_HIGH  (1),
        .LONG_CYCLES  (LONG_N),
        .REPEAT_CYCLES(REP_N),
        .NBITS        (6)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    // DUT pulse tallies gathered by the monitor
    int  dut_short = 0, dut_long = 0, dut_rel = 0, dut_rep = 0;

    // Reference model state: has the button been seen released since reset,
    // and how many consecutive active samples the current press has lasted.
    bit  armed = 1'b0;
    int  run   = 0;

    function automatic ev_t model(input logic b, input logic rst_n);
        ev_t e;
        e = '0;
        if (!rst_n) begin
            armed = 1'b0;
            run   = 0;
        end else if (!armed) begin
            if (!b) armed = 1'b1;
        end else if (b) begin
            run++;
            e.pressed      = 1'b1;
            e.long_press   = (run == LONG_N);
            e.repeat_press = REP_EN && (run > LONG_N) && (((run - LONG_N) % REP_N) == 0);
        end else begin
            if (run > 0) begin
                e.release_pulse = 1'b1;
                e.short_press   = (run < LONG_N);
            end
            run = 0;
        end
        return e;
    endfunction

    task automatic step(input logic b, input logic rst_n);
        @(negedge clk);
        bif.btn = b;
        reset_n = rst_n;
        exp_q.push_back(model(b, rst_n));
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    // Monitor: after each edge pop the expectation for it and compare
    initial begin
        ev_t got, want;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = '{bif.pressed, bif.short_press, bif.long_press,
                         bif.release_pulse, bif.repeat_press};
                dut_short += int'(got.short_press);
                dut_long  += int'(got.long_press);
                dut_rel   += int'(got.release_pulse);
                dut_rep   += int'(got.repeat_press);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got {prs,sht,lng,rel,rep}=%b expected %b",
                             cyc, got, want);
                end
            end
        end
    end

    int m_short, m_long, m_rel, m_rep;

    task automatic mark();
        m_short = dut_short; m_long = dut_long; m_rel = dut_rel; m_rep = dut_rep;
    endtask

    // Scenario-level tally check against the figures the test plan states
    task automatic expect_counts(input string name, input int s, input int l,
                                 input int r, input int rp);
        @(posedge clk);
        #2;
        n_checks++;
        if ((dut_short - m_short) != s || (dut_long - m_long) != l ||
            (dut_rel - m_rel) != r || (dut_rep - m_rep) != rp) begin
            n_fail++;
            $display("FAIL %s: got short/long/rel/rep=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     name, dut_short - m_short, dut_long - m_long, dut_rel - m_rel,
                     dut_rep - m_rep, s, l, r, rp);
        end
    endtask

    initial begin
        bif.btn = 1'b0;
        reset_n = 1'b0;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        hold(1'b0, 2);

        // Short press of 3 cycles
        mark(); hold(1'b1, 3); hold(1'b0, 3);
        expect_counts("short3", 1, 0, 1, 0);

        // Boundary: 7 active samples is still short
        mark(); hold(1'b1, 7); hold(1'b0, 3);
        expect_counts("short7", 1, 0, 1, 0);

        // Boundary: exactly 8 active samples is long
        mark(); hold(1'b1, 8); hold(1'b0, 3);
        expect_counts("long8", 0, 1, 1, 0);

        // Held through reset: no events at all, then a 2-cycle press is short
        mark();
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        hold(1'b1, 20); hold(1'b0, 3);
        expect_counts("held_reset", 0, 0, 0, 0);
        mark(); hold(1'b1, 2); hold(1'b0, 3);
        expect_counts("after_held", 1, 0, 1, 0);

        // Reset mid-press: no events until btn returns to 0
        mark();
        hold(1'b1, 4); step(1'b1, 1'b0); hold(1'b1, 10); hold(1'b0, 3);
        expect_counts("reset_mid", 0, 0, 0, 0);

        // Back-to-back presses with a single-cycle gap
        mark();
        hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 3);
        expect_counts("back2back", 2, 0, 2, 0);

        // 20-cycle hold: long press plus repeats when enabled
        mark(); hold(1'b1, 20); hold(1'b0, 3);
        expect_counts("hold20", 0, 1, 1, REP_EN ? 3 : 0);

        // Random press/gap lengths with occasional resets
        for (int i = 0; i < 120; i++) begin
            int len;
            len = $urandom_range(1, 22);
            if ($urandom_range(0, 29) == 0) step(1'b1, 1'b0);
            hold(1'b1, len);
            hold(1'b0, $urandom_range(1, 4));
        end

        hold(1'b0, 2);
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
